journey_selection: RTL and testbench

Ticket-fare calculator for the fare-calculator subsystem. It takes a route choice (path), a berth class, trip distances and passenger counts, and produces a registered 16-bit total fare. It is a fully pipelined datapath that accepts new inputs every clock and holds no other state. Downstream display/billing logic reads `total_cost` directly.

---
 rtl/journey_selection.sv | 134 +++++++++++++
 tb/tb_journey_selection.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/journey_selection.sv
// Ticket-fare calculator: three-stage pipeline from route/berth/distance/passenger inputs
// to a saturating 16-bit registered total fare.
module journey_selection (
   input  logic        clk,
   input  logic        rd,
   input  logic [2:0]  path,
   input  logic [1:0]  journey_type,
   input  logic [7:0]  distance,
   input  logic [7:0]  highway_distance,
   input  logic [7:0]  num_adults,
   input  logic [7:0]  num_children,
   output logic [15:0] total_cost
);

   localparam logic [2:0] PathNonStop = 3'b001;
   localparam logic [2:0] PathOneStop = 3'b010;
   localparam logic [2:0] PathTwoStop = 3'b011;
   localparam logic [2:0] PathLocal   = 3'b100;

   localparam logic [1:0] TypeSitting   = 2'b00;
   localparam logic [1:0] TypeSleeper   = 2'b01;
   localparam logic [1:0] TypeAcSleeper = 2'b10;

   // ---------------------------------------------------------------------------------------
   // Stage 1: decode, clamp, adult fare
   // ---------------------------------------------------------------------------------------
   logic [2:0]  rate;
   logic [4:0]  surcharge;
   logic        path_ok;
   logic        type_ok;
   logic [7:0]  hw;
   logic [10:0] adult_fare_d;
   logic        zero_d;

   always_comb begin
      rate    = 3'd0;
      type_ok = 1'b1;
      unique case (journey_type)
         TypeSitting:   rate = 3'd1;
         TypeSleeper:   rate = 3'd2;
         TypeAcSleeper: rate = 3'd4;
         default:       type_ok = 1'b0;
      endcase
   end

   always_comb begin
      surcharge = 5'd0;
      path_ok   = 1'b1;
      case (path)
         PathNonStop: surcharge = 5'd20;
         PathOneStop: surcharge = 5'd10;
         PathTwoStop: surcharge = 5'd5;
         PathLocal:   surcharge = 5'd0;
         default:     path_ok   = 1'b0;
      endcase
   end

   always_comb begin
      hw           = (highway_distance < distance) ? highway_distance : distance;
      // Max 1020 + 510 + 20 = 1550, fits 11 bits without overflow.
      adult_fare_d = (11'(distance) * 11'(rate)) + {2'b00, hw, 1'b0} + 11'(surcharge);
      // Children alone are never ticketed, so no adults forces zero as well.
      zero_d       = !path_ok || !type_ok || (num_adults == 8'd0) || (distance == 8'd0);
   end

   logic [10:0] adult_fare_s1_q;
   logic [7:0]  adults_s1_q;
   logic [7:0]  children_s1_q;
   logic        zero_s1_q;

   always_ff @(posedge clk or negedge rd) begin
      if (!rd) begin
         adult_fare_s1_q <= '0;
         adults_s1_q     <= '0;
         children_s1_q   <= '0;
         zero_s1_q       <= 1'b0;
      end else begin
         adult_fare_s1_q <= adult_fare_d;
         adults_s1_q     <= num_adults;
         children_s1_q   <= num_children;
         zero_s1_q       <= zero_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Stage 2: per-class products (255 x 1550 and 255 x 775 need 19 and 18 bits)
   // ---------------------------------------------------------------------------------------
   logic [18:0] adult_total_d;
   logic [17:0] child_total_d;

   always_comb begin
      adult_total_d = 19'(adults_s1_q) * 19'(adult_fare_s1_q);
      child_total_d = 18'(children_s1_q) * 18'(adult_fare_s1_q[10:1]);
   end

   logic [18:0] adult_total_s2_q;
   logic [17:0] child_total_s2_q;
   logic        zero_s2_q;

   always_ff @(posedge clk or negedge rd) begin
      if (!rd) begin
         adult_total_s2_q <= '0;
         child_total_s2_q <= '0;
         zero_s2_q        <= 1'b0;
      end else begin
         adult_total_s2_q <= adult_total_d;
         child_total_s2_q <= child_total_d;
         zero_s2_q        <= zero_s1_q;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Stage 3: sum, saturate, zero-force
   // ---------------------------------------------------------------------------------------
   logic [19:0] raw_total;
   logic [15:0] total_cost_d;

   always_comb begin
      raw_total    = 20'(adult_total_s2_q) + 20'(child_total_s2_q);
      total_cost_d = (raw_total[19:16] != 4'd0) ? 16'hFFFF : raw_total[15:0];
      if (zero_s2_q) begin
         total_cost_d = 16'd0;
      end
   end

   always_ff @(posedge clk or negedge rd) begin
      if (!rd) begin
         total_cost <= '0;
      end else begin
         total_cost <= total_cost_d;
      end
   end

endmodule

// File: tb/tb_journey_selection.sv
// Directed self-checking bench for journey_selection: latency, fares, clamp, zero cases,
// saturation, back-to-back pipelining and asynchronous reset.
module tb_journey_selection;

   logic        clk;
   logic        rd;
   logic [2:0]  path;
   logic [1:0]  journey_type;
   logic [7:0]  distance;
   logic [7:0]  highway_distance;
   logic [7:0]  num_adults;
   logic [7:0]  num_children;
   logic [15:0] total_cost;

   int errors = 0;
   int checks = 0;

   journey_selection dut (
      .clk              (clk),
      .rd               (rd),
      .path             (path),
      .journey_type     (journey_type),
      .distance         (distance),
      .highway_distance (highway_distance),
      .num_adults       (num_adults),
      .num_children     (num_children),
      .total_cost       (total_cost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_in(input logic [2:0] p, input logic [1:0] t, input logic [7:0] d,
                         input logic [7:0] h, input logic [7:0] a, input logic [7:0] c);
      path             = p;
      journey_type     = t;
      distance         = d;
      highway_distance = h;
      num_adults       = a;
      num_children     = c;
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] exp);
      checks++;
      assert (total_cost === exp)
      else begin
         errors++;
         $error("FAIL %s: total_cost=%0d expected=%0d", tag, total_cost, exp);
      end
   endtask

   // Apply one input set, wait the 3-edge latency, compare.
   task automatic run(input string tag, input logic [2:0] p, input logic [1:0] t,
                      input logic [7:0] d, input logic [7:0] h, input logic [7:0] a,
                      input logic [7:0] c, input logic [15:0] exp);
      set_in(p, t, d, h, a, c);
      step(3);
      check(tag, exp);
   endtask

   initial begin
      rd = 1'b1;
      set_in(3'b001, 2'b01, 8'd20, 8'd5, 8'd2, 8'd1);
      #1 rd = 1'b0;
      #1 check("reset_async", 16'd0);
      step(3);
      check("reset_held", 16'd0);

      set_in(3'b000, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
      #2 rd = 1'b1;
      step(4);
      check("reset_release_zero_inputs", 16'd0);

      run("nominal_sleeper", 3'b001, 2'b01, 8'd20, 8'd5, 8'd2, 8'd1, 16'd175);
      step(1);
      check("nominal_stable", 16'd175);
      run("nominal_sitting", 3'b001, 2'b00, 8'd20, 8'd5, 8'd2, 8'd1, 16'd125);
      run("nominal_ac", 3'b001, 2'b10, 8'd20, 8'd5, 8'd2, 8'd1, 16'd275);
      run("clamp_highway", 3'b010, 2'b00, 8'd10, 8'd50, 8'd1, 8'd1, 16'd60);
      run("child_round_down", 3'b011, 2'b00, 8'd6, 8'd0, 8'd1, 8'd1, 16'd16);
      run("local_path", 3'b100, 2'b01, 8'd30, 8'd10, 8'd3, 8'd2, 16'd320);
      run("two_stop_no_adults", 3'b011, 2'b00, 8'd1, 8'd0, 8'd0, 8'd0, 16'd0);

      run("setup_nonzero", 3'b001, 2'b01, 8'd20, 8'd5, 8'd2, 8'd1, 16'd175);
      run("path_none", 3'b000, 2'b01, 8'd20, 8'd5, 8'd2, 8'd1, 16'd0);
      run("setup_nonzero2", 3'b001, 2'b01, 8'd20, 8'd5, 8'd2, 8'd1, 16'd175);
      run("path_invalid", 3'b101, 2'b01, 8'd20, 8'd5, 8'd2, 8'd1, 16'd0);
      run("path_invalid_111", 3'b111, 2'b01, 8'd20, 8'd5, 8'd2, 8'd1, 16'd0);
      run("type_invalid", 3'b001, 2'b11, 8'd20, 8'd5, 8'd2, 8'd1, 16'd0);
      run("distance_zero", 3'b001, 2'b01, 8'd0, 8'd5, 8'd2, 8'd1, 16'd0);
      run("children_only", 3'b001, 2'b01, 8'd20, 8'd5, 8'd0, 8'd5, 16'd0);

      run("saturate", 3'b001, 2'b10, 8'd255, 8'd255, 8'd255, 8'd255, 16'd65535);
      run("below_limit", 3'b001, 2'b10, 8'd255, 8'd255, 8'd42, 8'd0, 16'd65100);

      // Three different sets on consecutive edges; results must emerge in order.
      set_in(3'b001, 2'b00, 8'd10, 8'd0, 8'd1, 8'd0);
      step(1);
      set_in(3'b010, 2'b01, 8'd10, 8'd5, 8'd2, 8'd2);
      step(1);
      set_in(3'b100, 2'b10, 8'd5, 8'd10, 8'd1, 8'd3);
      step(1);
      check("pipe_first", 16'd30);
      set_in(3'b000, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
      step(1);
      check("pipe_second", 16'd120);
      step(1);
      check("pipe_third", 16'd75);
      step(1);
      check("pipe_drain", 16'd0);

      // Reset mid-cycle with valid results in flight.
      set_in(3'b001, 2'b10, 8'd20, 8'd5, 8'd2, 8'd1);
      step(1);
      set_in(3'b001, 2'b00, 8'd20, 8'd5, 8'd2, 8'd1);
      step(1);
      #2 rd = 1'b0;
      #1 check("midflight_async", 16'd0);
      step(1);
      check("midflight_held", 16'd0);
      set_in(3'b001, 2'b01, 8'd20, 8'd5, 8'd2, 8'd1);
      #2 rd = 1'b1;
      step(1);
      check("release_edge1", 16'd0);
      step(1);
      check("release_edge2", 16'd0);
      step(1);
      check("release_edge3", 16'd175);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
